// File: rtl/clock_increment_if.sv
// Handshake bundle for clock_increment: start/pause control, start value and limit in,
// registered count, busy and done strobe out.
interface clock_increment_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] count_input;
  logic [WIDTH-1:0] limit;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count_output;
  logic             busy;
  logic             done;

  modport master (
    output count_input, limit, start, pause,
    input  count_output, busy, done
  );

  modport slave (
    input  count_input, limit, start, pause,
    output count_output, busy, done
  );
endinterface

// File: rtl/clock_increment.sv
// Loadable up-counter: counts from a loaded start value to a limit, strobes done, then
// either stops holding the limit (WRAP=0) or reloads the start value and repeats (WRAP=1).
module clock_increment #(
  parameter int WIDTH = 16,
  parameter int WRAP  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  clock_increment_if.slave      bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam bit               ONE_SHOT = (WRAP == 0);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic [WIDTH-1:0] count, count_next;
  logic [WIDTH-1:0] reload, reload_next;
  logic             done, done_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      done   <= done_next;
    end
  end

  // Restart beats pause, which beats the limit check; equality only, so start > limit
  // simply rolls over through zero before reaching the limit.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    done_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          count_next  = bus.count_input;
          reload_next = bus.count_input;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (bus.start) begin
          count_next  = bus.count_input;
          reload_next = bus.count_input;
        end else if (bus.pause) begin
          count_next = count;
        end else if (count == bus.limit) begin
          done_next = 1'b1;
          if (ONE_SHOT) begin
            state_next = IDLE;
          end else begin
            count_next = reload;
          end
        end else begin
          count_next = count + ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.count_output = count;
  assign bus.busy         = (state == RUN);
  assign bus.done         = done;

endmodule

// File: tb/tb_clock_increment.sv
// Bench for clock_increment: a one-shot and a periodic instance driven from a vector
// table; expected outputs are queued at drive time and popped after each clock edge.
module tb_clock_increment;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_increment_if #(.WIDTH(16)) bus_one ();
  clock_increment_if #(.WIDTH(16)) bus_per ();

  clock_increment #(.WIDTH(16), .WRAP(0)) u_one (.clk(clk), .rst(rst), .bus(bus_one));
  clock_increment #(.WIDTH(16), .WRAP(1)) u_per (.clk(clk), .rst(rst), .bus(bus_per));

  typedef struct {
    bit          sel;    // 0: one-shot instance, 1: periodic instance
    bit          start;
    bit          pause;
    logic [15:0] din;
    logic [15:0] lim;
    logic [15:0] cnt;
    logic        busy;
    logic        done;
  } vec_t;

  typedef struct {
    bit          sel;
    logic [15:0] cnt;
    logic        busy;
    logic        done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, step_no, got, exp);
    end
  endtask

  function automatic void add(input bit sel, input bit st, input bit pa,
                              input logic [15:0] din, input logic [15:0] lim,
                              input logic [15:0] cnt, input logic b, input logic d);
    vec_t v;
    v.sel = sel; v.start = st; v.pause = pa; v.din = din; v.lim = lim;
    v.cnt = cnt; v.busy = b; v.done = d;
    vecs.push_back(v);
  endfunction

  task automatic step(input vec_t v);
    exp_t e;
    if (v.sel) begin
      bus_per.start = v.start; bus_per.pause = v.pause;
      bus_per.count_input = v.din; bus_per.limit = v.lim;
      bus_one.start = 1'b0; bus_one.pause = 1'b0;
    end else begin
      bus_one.start = v.start; bus_one.pause = v.pause;
      bus_one.count_input = v.din; bus_one.limit = v.lim;
      bus_per.start = 1'b0; bus_per.pause = 1'b0;
    end
    sb.push_back('{v.sel, v.cnt, v.busy, v.done});
    @(posedge clk);
    #1;
    step_no++;
    e = sb.pop_front();
    if (e.sel) begin
      cmp("per_count", bus_per.count_output, e.cnt);
      cmp("per_busy",  {15'd0, bus_per.busy}, {15'd0, e.busy});
      cmp("per_done",  {15'd0, bus_per.done}, {15'd0, e.done});
    end else begin
      cmp("one_count", bus_one.count_output, e.cnt);
      cmp("one_busy",  {15'd0, bus_one.busy}, {15'd0, e.busy});
      cmp("one_done",  {15'd0, bus_one.done}, {15'd0, e.done});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus_one.start = 0; bus_one.pause = 0; bus_one.count_input = 0; bus_one.limit = 0;
    bus_per.start = 0; bus_per.pause = 0; bus_per.count_input = 0; bus_per.limit = 0;

    // Power-on reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_one_count", bus_one.count_output, 16'h0000);
    cmp("rst_one_busy",  {15'd0, bus_one.busy}, 16'h0);
    cmp("rst_one_done",  {15'd0, bus_one.done}, 16'h0);
    cmp("rst_per_count", bus_per.count_output, 16'h0000);
    cmp("rst_per_busy",  {15'd0, bus_per.busy}, 16'h0);
    rst = 1'b0;

    // Reset mid-count: A=1, L=0x10, reset between edges after S+5
    step('{0, 1, 0, 16'h0001, 16'h0010, 16'h0001, 1, 0});
    for (int i = 2; i <= 6; i++)
      step('{0, 0, 0, 16'h0001, 16'h0010, 16'(i), 1, 0});
    #2 rst = 1'b1;
    #1;
    cmp("midrst_count", bus_one.count_output, 16'h0000);
    cmp("midrst_busy",  {15'd0, bus_one.busy}, 16'h0);
    cmp("midrst_done",  {15'd0, bus_one.done}, 16'h0);
    // start is ignored while reset is held across an edge
    bus_one.start = 1'b1; bus_one.count_input = 16'h0055;
    @(posedge clk);
    #1;
    cmp("rsthold_count", bus_one.count_output, 16'h0000);
    cmp("rsthold_busy",  {15'd0, bus_one.busy}, 16'h0);
    #2 rst = 1'b0;
    // First start after release is accepted at the next edge
    step('{0, 1, 0, 16'h0022, 16'h0030, 16'h0022, 1, 0});

    // One-shot basic: A=1, L=4
    add(0, 1, 0, 16'h0001, 16'h0004, 16'h0001, 1, 0);
    add(0, 0, 0, 16'h0001, 16'h0004, 16'h0002, 1, 0);
    add(0, 0, 0, 16'h0001, 16'h0004, 16'h0003, 1, 0);
    add(0, 0, 0, 16'h0001, 16'h0004, 16'h0004, 1, 0);
    add(0, 0, 0, 16'h0001, 16'h0004, 16'h0004, 0, 1);
    add(0, 0, 0, 16'h0001, 16'h0004, 16'h0004, 0, 0);
    add(0, 0, 0, 16'h0001, 16'h0004, 16'h0004, 0, 0);
    // Roll-over: A=FFFE, L=1
    add(0, 1, 0, 16'hFFFE, 16'h0001, 16'hFFFE, 1, 0);
    add(0, 0, 0, 16'hFFFE, 16'h0001, 16'hFFFF, 1, 0);
    add(0, 0, 0, 16'hFFFE, 16'h0001, 16'h0000, 1, 0);
    add(0, 0, 0, 16'hFFFE, 16'h0001, 16'h0001, 1, 0);
    add(0, 0, 0, 16'hFFFE, 16'h0001, 16'h0001, 0, 1);
    add(0, 0, 0, 16'hFFFE, 16'h0001, 16'h0001, 0, 0);
    // Pause for three cycles after S+1: done after S+8
    add(0, 1, 0, 16'hABC1, 16'hABC5, 16'hABC1, 1, 0);
    add(0, 0, 0, 16'hABC1, 16'hABC5, 16'hABC2, 1, 0);
    add(0, 0, 1, 16'hABC1, 16'hABC5, 16'hABC2, 1, 0);
    add(0, 0, 1, 16'hABC1, 16'hABC5, 16'hABC2, 1, 0);
    add(0, 0, 1, 16'hABC1, 16'hABC5, 16'hABC2, 1, 0);
    add(0, 0, 0, 16'hABC1, 16'hABC5, 16'hABC3, 1, 0);
    add(0, 0, 0, 16'hABC1, 16'hABC5, 16'hABC4, 1, 0);
    add(0, 0, 0, 16'hABC1, 16'hABC5, 16'hABC5, 1, 0);
    add(0, 0, 0, 16'hABC1, 16'hABC5, 16'hABC5, 0, 1);
    add(0, 0, 0, 16'hABC1, 16'hABC5, 16'hABC5, 0, 0);
    // Restart at S+3 with FFAA: reload, no done
    add(0, 1, 0, 16'hABC1, 16'hABC5, 16'hABC1, 1, 0);
    add(0, 0, 0, 16'hABC1, 16'hABC5, 16'hABC2, 1, 0);
    add(0, 0, 0, 16'hABC1, 16'hABC5, 16'hABC3, 1, 0);
    add(0, 1, 0, 16'hFFAA, 16'hABC5, 16'hFFAA, 1, 0);
    add(0, 0, 0, 16'hFFAA, 16'hABC5, 16'hFFAB, 1, 0);
    add(0, 0, 0, 16'hFFAA, 16'hABC5, 16'hFFAC, 1, 0);
    // Start on the would-be done edge wins; then start in the IDLE done cycle with A=L=7
    add(0, 1, 0, 16'h0001, 16'h0003, 16'h0001, 1, 0);
    add(0, 0, 0, 16'h0001, 16'h0003, 16'h0002, 1, 0);
    add(0, 0, 0, 16'h0001, 16'h0003, 16'h0003, 1, 0);
    add(0, 1, 0, 16'h0002, 16'h0003, 16'h0002, 1, 0);
    add(0, 0, 0, 16'h0002, 16'h0003, 16'h0003, 1, 0);
    add(0, 0, 0, 16'h0002, 16'h0003, 16'h0003, 0, 1);
    add(0, 1, 0, 16'h0007, 16'h0007, 16'h0007, 1, 0);
    add(0, 0, 0, 16'h0007, 16'h0007, 16'h0007, 0, 1);
    add(0, 0, 0, 16'h0007, 16'h0007, 16'h0007, 0, 0);
    // Periodic: A=CEAB, L=CEAD, done every 3 cycles, busy stays high
    add(1, 1, 0, 16'hCEAB, 16'hCEAD, 16'hCEAB, 1, 0);
    add(1, 0, 0, 16'hCEAB, 16'hCEAD, 16'hCEAC, 1, 0);
    add(1, 0, 0, 16'hCEAB, 16'hCEAD, 16'hCEAD, 1, 0);
    add(1, 0, 0, 16'hCEAB, 16'hCEAD, 16'hCEAB, 1, 1);
    add(1, 0, 0, 16'hCEAB, 16'hCEAD, 16'hCEAC, 1, 0);
    add(1, 0, 0, 16'hCEAB, 16'hCEAD, 16'hCEAD, 1, 0);
    add(1, 0, 0, 16'hCEAB, 16'hCEAD, 16'hCEAB, 1, 1);
    add(1, 0, 0, 16'hCEAB, 16'hCEAD, 16'hCEAC, 1, 0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i]);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
